synth_event_sync: RTL and testbench
===================================

SYNTH_EVENT_SYNC -- requirements
Module: synth_event_sync

Interface
REQ-001 VOICES, default 8: number of voices.
REQ-002 V_WIDTH, default 3: voice index width, equal to log2(VOICES).
REQ-003 E_WIDTH, default 3: envelope-slot index width per voice.
REQ-004 DEPTH, default 4: event FIFO depth, a power of two and at least 2.
REQ-005 OSC_CLK  in  1: the single clock; one clock, all logic on rising edge.
REQ-006 iRST  in  1: reset, asynchronous, active-high.
REQ-007 xxxx  in  V_WIDTH+E_WIDTH: slot counter from timing_gen; a frame starts when it wraps to 0.
REQ-008 note_on  in  1: level from midi_decoder; each rising edge is one note event.
REQ-009 cur_key_adr  in  V_WIDTH, cur_key_val  in  8, cur_vel_on  in  8: event payload, valid on the note_on rising edge.
REQ-010 keys_on  in  VOICES, voice_free  in  VOICES: voice status vectors, asynchronous to the frame.
REQ-011 ev_note_on  out  1, ev_key_adr  out  V_WIDTH, ev_key_val  out  8, ev_vel  out  8: event presented to pitch_control for one full frame.
REQ-012 keys_on_sync  out  VOICES, voice_free_sync  out  VOICES: status vectors sampled at frame start.
REQ-013 fifo_level  out  log2(DEPTH)+1: FIFO occupancy.
REQ-014 overflow  out  1: sticky flag, set when an event is dropped.

Function
REQ-015 frame_start SHALL be a one-cycle pulse, registered, asserted when xxxx==0 and xxxx was nonzero on the previous cycle; xxxx stuck at 0 gives no further pulses.
REQ-016 A rising edge of note_on, detected against a one-cycle-delayed copy, SHALL push {cur_key_adr, cur_key_val, cur_vel_on} into the FIFO on the next edge.
REQ-017 A push while fifo_level==DEPTH with no simultaneous pop SHALL be dropped and SHALL set overflow; the FIFO contents SHALL NOT change.
REQ-018 The FSM SHALL have the states IDLE, ISSUE and GAP.
REQ-019 IDLE to ISSUE SHALL occur on frame_start with the FIFO non-empty: pop the head, load the ev_* outputs, set ev_note_on=1.
REQ-020 In ISSUE, ev_* SHALL hold stable until the next frame_start; that edge SHALL go to GAP with ev_note_on=0 and the payload held.
REQ-021 GAP SHALL last exactly one frame; at the next frame_start go to ISSUE if the FIFO is non-empty, else to IDLE. Back-to-back events are therefore separated by one note_on-low frame.
REQ-022 A push and a pop on the same cycle SHALL leave fifo_level unchanged and SHALL succeed even when full.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL equal wr-rd, using one extra pointer bit.
REQ-024 keys_on_sync and voice_free_sync SHALL load on every frame_start, regardless of FSM state.
REQ-025 Event latency, from the note_on edge to ev_note_on high, SHALL be at most 2 cycles plus the wait to the next frame_start when the FIFO is empty and the FSM is in IDLE.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 While iRST is high: all outputs 0, FIFO empty, pointers 0, FSM in IDLE, edge-detect registers 0.
REQ-028 Reset mid-event SHALL discard queued events; after release, the first frame_start needs a fresh nonzero-to-zero transition of xxxx.

Configuration
REQ-029 With SYNTH_EVT_VELOFF_EN defined, the module SHALL add input cur_vel_off (8) and output ev_vel_off (8); falling edges of note_on SHALL queue note-off events with ev_note_on=0 and ev_vel_off valid, using the same FIFO, FSM and ISSUE timing.
REQ-030 With SYNTH_EVT_VELOFF_EN undefined, those ports SHALL be absent, falling edges SHALL be ignored, and the FIFO word SHALL carry no off flag.

Structure
REQ-031 Package synth_pkg SHALL hold the FSM state enum, the event record typedef and the default VOICES, V_WIDTH and E_WIDTH constants.
REQ-032 The FIFO SHALL be a sub-module, synth_evt_fifo (parametrised width and DEPTH); edge detection and the FSM stay in the top module.

Verification
REQ-033 Single event: xxxx cycles 0..63, note_on rises with key 60 on voice 3 and vel 100 -> ev_note_on=1 at the next frame_start with ev_key_val=60, ev_key_adr=3, ev_vel=100, held 64 cycles, then 0 for 64 cycles.
REQ-034 Burst: 3 note_on edges in one frame -> 3 ISSUE frames interleaved with GAP frames, in order; fifo_level steps 3,2,1,0.
REQ-035 Overflow: DEPTH+1 edges before a frame_start -> fifo_level=DEPTH, overflow=1, and the last event is never issued.
REQ-036 Simultaneous push/pop when full at frame_start -> level stays DEPTH, overflow stays 0.
REQ-037 Reset asserted during ISSUE with 2 queued events -> outputs 0 immediately, FIFO empty, no event issued after release.
REQ-038 SYNTH_EVT_VELOFF_EN build: note_on high then low with cur_vel_off=40 -> a note-on frame, then after GAP a frame with ev_note_on=0 and ev_vel_off=40.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg -- shared types and constants for the synth event synchroniser.
//
// Contents:
//   DEF_VOICES / DEF_V_WIDTH / DEF_E_WIDTH : default voice count and index widths
//   evt_state_t     : issue FSM states (IDLE, ISSUE, GAP)
//   synth_evt_t     : one queued note event for the default voice width
//   synth_evt_width : FIFO word width for a given voice index width
//
// Optional feature macro: SYNTH_EVT_VELOFF_EN adds a note-off flag and the
// release velocity to the event record.
package synth_pkg;

  localparam int DEF_VOICES  = 8;
  localparam int DEF_V_WIDTH = 3;
  localparam int DEF_E_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } evt_state_t;

  // Field order matches the FIFO word packing in synth_event_sync:
  // the most significant fields come first.
  typedef struct packed {
`ifdef SYNTH_EVT_VELOFF_EN
    logic                   off;
    logic [7:0]             vel_off;
`endif
    logic [DEF_V_WIDTH-1:0] key_adr;
    logic [7:0]             key_val;
    logic [7:0]             vel;
  } synth_evt_t;

  // Key value and on-velocity take 16 bits; the note-off build adds the
  // off flag and the release velocity.
  function automatic int synth_evt_width(input int v_width);
`ifdef SYNTH_EVT_VELOFF_EN
    return v_width + 16 + 9;
`else
    return v_width + 16;
`endif
  endfunction

endpackage

// File: rtl/synth_evt_fifo.sv
// synth_evt_fifo -- small show-ahead event FIFO.
//
// Ports:
//   OSC_CLK, iRST       : clock, asynchronous active-high reset
//   wr_en, wr_data      : push request and word
//   rd_en, rd_data      : pop request; rd_data always shows the head word
//   level               : occupancy (wr_ptr - rd_ptr), 0..DEPTH
//   empty               : no words stored
//   drop                : push refused because the FIFO is full and no pop
//                         frees a slot on the same cycle
//
// DEPTH must be a power of two and at least 2. Pointers carry one extra bit
// so that full and empty are distinguishable and level is a plain subtract.
module synth_evt_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     OSC_CLK,
  input  logic                     iRST,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (level == DEPTH_L);

  // A pop on the same cycle frees the head slot, so a push into a full
  // FIFO still succeeds: it lands in the slot being read out.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign drop  = wr_en && full && !do_rd;

  // Head word is read combinationally so the consumer can load it on the
  // same edge that pops it.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge OSC_CLK) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/synth_event_sync.sv
// synth_event_sync -- aligns note events from the MIDI decoder to the voice
// frame produced by timing_gen.
//
// Ports:
//   OSC_CLK, iRST                  : clock, asynchronous active-high reset
//   xxxx                           : slot counter; a frame starts on its wrap to 0
//   note_on                        : note level; each rising edge is one event
//   cur_key_adr/val, cur_vel_on    : event payload, valid on the note_on edge
//   keys_on, voice_free            : voice status vectors
//   ev_note_on, ev_key_adr,
//   ev_key_val, ev_vel             : event presented for one whole frame
//   keys_on_sync, voice_free_sync  : status vectors sampled at frame start
//   fifo_level                     : queued events
//   overflow                       : sticky, an event was dropped
//
// Optional feature macro SYNTH_EVT_VELOFF_EN: adds cur_vel_off / ev_vel_off
// and queues falling edges of note_on as note-off events (ev_note_on = 0).
module synth_event_sync
  import synth_pkg::*;
#(
  parameter int VOICES  = DEF_VOICES,
  parameter int V_WIDTH = DEF_V_WIDTH,
  parameter int E_WIDTH = DEF_E_WIDTH,
  parameter int DEPTH   = 4
) (
  input  logic                       OSC_CLK,
  input  logic                       iRST,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic                       note_on,
  input  logic [V_WIDTH-1:0]         cur_key_adr,
  input  logic [7:0]                 cur_key_val,
  input  logic [7:0]                 cur_vel_on,
`ifdef SYNTH_EVT_VELOFF_EN
  input  logic [7:0]                 cur_vel_off,
  output logic [7:0]                 ev_vel_off,
`endif
  input  logic [VOICES-1:0]          keys_on,
  input  logic [VOICES-1:0]          voice_free,
  output logic                       ev_note_on,
  output logic [V_WIDTH-1:0]         ev_key_adr,
  output logic [7:0]                 ev_key_val,
  output logic [7:0]                 ev_vel,
  output logic [VOICES-1:0]          keys_on_sync,
  output logic [VOICES-1:0]          voice_free_sync,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int XW    = V_WIDTH + E_WIDTH;
  localparam int EVT_W = synth_evt_width(V_WIDTH);

  // Edge detection and frame-start pulse.
  logic          note_on_d_reg;
  logic [XW-1:0] xxxx_d_reg;
  logic          frame_start_reg;
  logic          push;
  logic [EVT_W-1:0] wr_word;

  // FIFO interface.
  logic [EVT_W-1:0]          head_word;
  logic                      fifo_empty;
  logic                      fifo_drop;

  // FSM.
  evt_state_t state_reg;
  evt_state_t state_next;
  logic       pop;
  logic       load_evt;
  logic       end_evt;

  // Registered outputs.
  logic               ev_note_on_reg;
  logic [V_WIDTH-1:0] ev_key_adr_reg;
  logic [7:0]         ev_key_val_reg;
  logic [7:0]         ev_vel_reg;
  logic [VOICES-1:0]  keys_on_sync_reg;
  logic [VOICES-1:0]  voice_free_sync_reg;
  logic               overflow_reg;
  logic               head_is_on;

`ifdef SYNTH_EVT_VELOFF_EN
  logic       note_fall;
  logic [7:0] ev_vel_off_reg;

  assign note_fall  = !note_on && note_on_d_reg;
  assign push       = (note_on && !note_on_d_reg) || note_fall;
  assign wr_word    = {note_fall, cur_vel_off, cur_key_adr, cur_key_val, cur_vel_on};
  assign head_is_on = !head_word[EVT_W-1];
  assign ev_vel_off = ev_vel_off_reg;
`else
  assign push       = note_on && !note_on_d_reg;
  assign wr_word    = {cur_key_adr, cur_key_val, cur_vel_on};
  assign head_is_on = 1'b1;
`endif

  synth_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .OSC_CLK (OSC_CLK),
    .iRST    (iRST),
    .wr_en   (push),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // IDLE waits for work, ISSUE holds an event for one frame, GAP holds the
  // note low for one frame so consecutive events are always separated.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load_evt   = 1'b0;
    end_evt    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start_reg && !fifo_empty) begin
          state_next = ISSUE;
          pop        = 1'b1;
          load_evt   = 1'b1;
        end
      end
      ISSUE: begin
        if (frame_start_reg) begin
          state_next = GAP;
          end_evt    = 1'b1;
        end
      end
      GAP: begin
        if (frame_start_reg) begin
          if (!fifo_empty) begin
            state_next = ISSUE;
            pop        = 1'b1;
            load_evt   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      state_reg           <= IDLE;
      note_on_d_reg       <= 1'b0;
      xxxx_d_reg          <= '0;
      frame_start_reg     <= 1'b0;
      ev_note_on_reg      <= 1'b0;
      ev_key_adr_reg      <= '0;
      ev_key_val_reg      <= '0;
      ev_vel_reg          <= '0;
      keys_on_sync_reg    <= '0;
      voice_free_sync_reg <= '0;
      overflow_reg        <= 1'b0;
`ifdef SYNTH_EVT_VELOFF_EN
      ev_vel_off_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      note_on_d_reg <= note_on;
      xxxx_d_reg    <= xxxx;
      // Only a nonzero-to-zero transition starts a frame; a counter parked
      // at zero (or the zero seen right after reset) does not.
      frame_start_reg <= (xxxx == '0) && (xxxx_d_reg != '0);

      if (frame_start_reg) begin
        keys_on_sync_reg    <= keys_on;
        voice_free_sync_reg <= voice_free;
      end

      if (fifo_drop) begin
        overflow_reg <= 1'b1;
      end

      if (load_evt) begin
        ev_note_on_reg <= head_is_on;
        ev_key_adr_reg <= head_word[16 +: V_WIDTH];
        ev_key_val_reg <= head_word[15:8];
        ev_vel_reg     <= head_word[7:0];
`ifdef SYNTH_EVT_VELOFF_EN
        ev_vel_off_reg <= head_word[16 + V_WIDTH +: 8];
`endif
      end else if (end_evt) begin
        ev_note_on_reg <= 1'b0;
      end
    end
  end

  assign ev_note_on      = ev_note_on_reg;
  assign ev_key_adr      = ev_key_adr_reg;
  assign ev_key_val      = ev_key_val_reg;
  assign ev_vel          = ev_vel_reg;
  assign keys_on_sync    = keys_on_sync_reg;
  assign voice_free_sync = voice_free_sync_reg;
  assign overflow        = overflow_reg;

endmodule

// File: tb/tb_synth_event_sync.sv
// tb_synth_event_sync -- directed scenarios plus randomized traffic, all
// checked against a frame-level reference model (event queue + "did the
// previous frame carry an event" flag).
module tb_synth_event_sync;
  import synth_pkg::*;

  localparam int VOICES  = DEF_VOICES;
  localparam int V_WIDTH = DEF_V_WIDTH;
  localparam int E_WIDTH = DEF_E_WIDTH;
  localparam int DEPTH   = 4;
  localparam int XW      = V_WIDTH + E_WIDTH;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               OSC_CLK = 1'b0;
  logic               iRST = 1'b1;
  logic [XW-1:0]      xxxx = '0;
  logic               note_on = 1'b0;
  logic [V_WIDTH-1:0] cur_key_adr = '0;
  logic [7:0]         cur_key_val = '0;
  logic [7:0]         cur_vel_on = '0;
  logic [VOICES-1:0]  keys_on = '0;
  logic [VOICES-1:0]  voice_free = '0;
  logic               ev_note_on;
  logic [V_WIDTH-1:0] ev_key_adr;
  logic [7:0]         ev_key_val;
  logic [7:0]         ev_vel;
  logic [VOICES-1:0]  keys_on_sync;
  logic [VOICES-1:0]  voice_free_sync;
  logic [LW-1:0]      fifo_level;
  logic               overflow;
`ifdef SYNTH_EVT_VELOFF_EN
  logic [7:0]         cur_vel_off = '0;
  logic [7:0]         ev_vel_off;
`endif

  synth_event_sync #(
    .VOICES (VOICES), .V_WIDTH (V_WIDTH), .E_WIDTH (E_WIDTH), .DEPTH (DEPTH)
  ) dut (
    .OSC_CLK         (OSC_CLK),
    .iRST            (iRST),
    .xxxx            (xxxx),
    .note_on         (note_on),
    .cur_key_adr     (cur_key_adr),
    .cur_key_val     (cur_key_val),
    .cur_vel_on      (cur_vel_on),
`ifdef SYNTH_EVT_VELOFF_EN
    .cur_vel_off     (cur_vel_off),
    .ev_vel_off      (ev_vel_off),
`endif
    .keys_on         (keys_on),
    .voice_free      (voice_free),
    .ev_note_on      (ev_note_on),
    .ev_key_adr      (ev_key_adr),
    .ev_key_val      (ev_key_val),
    .ev_vel          (ev_vel),
    .keys_on_sync    (keys_on_sync),
    .voice_free_sync (voice_free_sync),
    .fifo_level      (fifo_level),
    .overflow        (overflow)
  );

  always #5 OSC_CLK = ~OSC_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  synth_evt_t         mq[$];
  logic               m_on;
  logic [V_WIDTH-1:0] m_adr;
  logic [7:0]         m_val;
  logic [7:0]         m_vel;
  logic [7:0]         m_voff;
  logic [VOICES-1:0]  m_keys;
  logic [VOICES-1:0]  m_free;
  logic               m_ovf;
  bit                 m_last_issue;
  bit                 m_fs;
  logic [XW-1:0]      m_x_prev;
  logic               m_n_prev;

  task automatic model_reset();
    mq.delete();
    m_on = 0; m_adr = '0; m_val = '0; m_vel = '0; m_voff = '0;
    m_keys = '0; m_free = '0; m_ovf = 0; m_last_issue = 0;
    m_fs = 0; m_x_prev = '0; m_n_prev = 0;
  endtask

  // One rising clock edge: frame boundary handling, then the note edge.
  task automatic model_edge();
    synth_evt_t ent;
    int pre;
    bit pop;
    bit push;
    pre  = mq.size();
    pop  = 0;
    push = 0;
    if (m_fs) begin
      if (m_last_issue) begin
        m_on = 0;
        m_last_issue = 0;
      end else if (pre > 0) begin
        ent = mq.pop_front();
        pop = 1;
        m_last_issue = 1;
        m_adr = ent.key_adr; m_val = ent.key_val; m_vel = ent.vel;
`ifdef SYNTH_EVT_VELOFF_EN
        m_voff = ent.vel_off;
        m_on   = !ent.off;
`else
        m_on   = 1;
`endif
      end
      m_keys = keys_on;
      m_free = voice_free;
    end
    ent = '0;
    ent.key_adr = cur_key_adr; ent.key_val = cur_key_val; ent.vel = cur_vel_on;
    if (note_on && !m_n_prev) push = 1;
`ifdef SYNTH_EVT_VELOFF_EN
    ent.vel_off = cur_vel_off;
    if (!note_on && m_n_prev) begin
      push = 1;
      ent.off = 1;
    end
`endif
    if (push) begin
      if (pre == DEPTH && !pop) m_ovf = 1;
      else mq.push_back(ent);
    end
    m_fs     = (xxxx == 0) && (m_x_prev != 0);
    m_x_prev = xxxx;
    m_n_prev = note_on;
  endtask

  task automatic compare_all();
    check("ev_note_on", 32'(ev_note_on), 32'(m_on));
    check("ev_key_adr", 32'(ev_key_adr), 32'(m_adr));
    check("ev_key_val", 32'(ev_key_val), 32'(m_val));
    check("ev_vel", 32'(ev_vel), 32'(m_vel));
    check("keys_on_sync", 32'(keys_on_sync), 32'(m_keys));
    check("voice_free_sync", 32'(voice_free_sync), 32'(m_free));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SYNTH_EVT_VELOFF_EN
    check("ev_vel_off", 32'(ev_vel_off), 32'(m_voff));
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  int cnt = 0;
  int frame_len = 64;
  int stuck = 0;

  task automatic tick();
    xxxx = XW'(cnt);
    @(posedge OSC_CLK);
    if (iRST) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (stuck > 0) stuck--;
    else cnt = (cnt + 1 >= frame_len) ? 0 : cnt + 1;
  endtask

  task automatic wait_cnt(input int c);
    int guard;
    guard = 0;
    while (cnt != c && guard < 200) begin
      tick();
      guard++;
    end
    check("wait_cnt_timeout", 32'(guard >= 200), 32'd0);
  endtask

  task automatic push_event(input logic [7:0] val);
    cur_key_adr = V_WIDTH'(val);
    cur_key_val = val;
    cur_vel_on  = val + 8'd1;
    note_on = 1'b1;
    tick();
    note_on = 1'b0;
    tick();
  endtask

  task automatic do_reset(input bit check_regs);
    iRST = 1'b1;
    note_on = 1'b0;
    keys_on = VOICES'($urandom);
    voice_free = VOICES'($urandom);
    frame_len = 64;
    stuck = 0;
    repeat (3) tick();
    if (check_regs) begin
      check("rst_ev_note_on", 32'(ev_note_on), 32'd0);
      check("rst_ev_key_val", 32'(ev_key_val), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_keys_on_sync", 32'(keys_on_sync), 32'd0);
    end
    iRST = 1'b0;
    cnt = 0;
  endtask

  int hi;
  int rises;
  bit prev_on;
  bit seen_last;
  logic [7:0] got_val;
  logic [V_WIDTH-1:0] got_adr;
  logic [7:0] got_vel;
  logic [7:0] issued[$];

  task automatic run_and_record(input int n);
    hi = 0;
    rises = 0;
    prev_on = ev_note_on;
    issued.delete();
    repeat (n) begin
      tick();
      if (ev_note_on) hi++;
      if (ev_note_on && !prev_on) begin
        rises++;
        issued.push_back(ev_key_val);
        got_val = ev_key_val; got_adr = ev_key_adr; got_vel = ev_vel;
      end
      prev_on = ev_note_on;
    end
  endtask

  initial begin
    model_reset();

    // Single event, 64-slot frames.
    do_reset(1'b1);
    wait_cnt(10);
    cur_key_adr = 3'd3; cur_key_val = 8'd60; cur_vel_on = 8'd100;
    note_on = 1'b1;
    run_and_record(200);
    $display("single: rises=%0d hold=%0d key=%0d adr=%0d vel=%0d", rises, hi, got_val, got_adr, got_vel);
    check("single_rises", 32'(rises), 32'd1);
    check("single_hold", 32'(hi), 32'd64);
    check("single_key", 32'(got_val), 32'd60);
    check("single_adr", 32'(got_adr), 32'd3);
    check("single_vel", 32'(got_vel), 32'd100);

`ifndef SYNTH_EVT_VELOFF_EN
    // Burst of three events in one frame.
    do_reset(1'b0);
    wait_cnt(5);
    push_event(8'h11); push_event(8'h22); push_event(8'h33);
    check("burst_level", 32'(fifo_level), 32'd3);
    run_and_record(8 * 64);
    $display("burst: rises=%0d hold=%0d", rises, hi);
    check("burst_rises", 32'(rises), 32'd3);
    check("burst_hold", 32'(hi), 32'd192);
    if (issued.size() == 3) begin
      check("burst_order0", 32'(issued[0]), 32'h11);
      check("burst_order1", 32'(issued[1]), 32'h22);
      check("burst_order2", 32'(issued[2]), 32'h33);
    end

    // Push and pop on the same edge while full.
    do_reset(1'b0);
    wait_cnt(5);
    for (int i = 0; i < DEPTH; i++) push_event(8'(8'h40 + i));
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    wait_cnt(1);
    cur_key_val = 8'h77; cur_vel_on = 8'h78; cur_key_adr = 3'd7;
    note_on = 1'b1;
    tick();
    $display("push_pop_full: level=%0d overflow=%0d ev=%0h", fifo_level, overflow, ev_key_val);
    check("pp_level", 32'(fifo_level), 32'(DEPTH));
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_ev_on", 32'(ev_note_on), 32'd1);
    check("pp_ev_val", 32'(ev_key_val), 32'h40);
    note_on = 1'b0;
    tick();

    // Overflow: DEPTH+1 pushes before a frame start.
    do_reset(1'b0);
    wait_cnt(5);
    for (int i = 0; i <= DEPTH; i++) push_event(8'(8'h80 + i));
    check("ovf_level", 32'(fifo_level), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    run_and_record((2 * DEPTH + 3) * 64);
    seen_last = 0;
    foreach (issued[k]) if (issued[k] == 8'(8'h80 + DEPTH)) seen_last = 1;
    $display("overflow: issued=%0d dropped_seen=%0d", rises, seen_last);
    check("ovf_issued", 32'(rises), 32'(DEPTH));
    check("ovf_last_dropped", 32'(seen_last), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Reset during ISSUE with two events still queued.
    do_reset(1'b0);
    wait_cnt(5);
    push_event(8'h51); push_event(8'h52); push_event(8'h53);
    begin
      int guard;
      guard = 0;
      while (!ev_note_on && guard < 200) begin
        tick();
        guard++;
      end
      check("rst_mid_timeout", 32'(guard >= 200), 32'd0);
    end
`ifndef SYNTH_EVT_VELOFF_EN
    check("rst_mid_queued", 32'(fifo_level), 32'd2);
`endif
    #2;
    iRST = 1'b1;
    model_reset();
    #1;
    $display("reset_mid: ev_note_on=%0d level=%0d", ev_note_on, fifo_level);
    check("rst_mid_on", 32'(ev_note_on), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    compare_all();
    repeat (2) tick();
    iRST = 1'b0;
    run_and_record(4 * 64);
    check("rst_mid_no_issue", 32'(hi), 32'd0);

`ifdef SYNTH_EVT_VELOFF_EN
    // Note-on followed by note-off with a release velocity.
    do_reset(1'b0);
    wait_cnt(5);
    cur_key_adr = 3'd2; cur_key_val = 8'd61; cur_vel_on = 8'd100; cur_vel_off = 8'd0;
    note_on = 1'b1;
    repeat (3) tick();
    cur_vel_off = 8'd40;
    note_on = 1'b0;
    run_and_record(300);
    $display("veloff: rises=%0d hold=%0d vel_off=%0d", rises, hi, ev_vel_off);
    check("voff_rises", 32'(rises), 32'd1);
    check("voff_hold", 32'(hi), 32'd64);
    check("voff_vel_off", 32'(ev_vel_off), 32'd40);
    check("voff_note_low", 32'(ev_note_on), 32'd0);
`endif

    // Randomized traffic: variable frame lengths, parked counter, resets.
    do_reset(1'b0);
    for (int t = 0; t < 4000; t++) begin
      keys_on    = VOICES'($urandom);
      voice_free = VOICES'($urandom);
      cur_key_adr = V_WIDTH'($urandom);
      cur_key_val = 8'($urandom);
      cur_vel_on  = 8'($urandom);
`ifdef SYNTH_EVT_VELOFF_EN
      cur_vel_off = 8'($urandom);
`endif
      if ($urandom_range(0, 5) == 0) note_on = ~note_on;
      if (cnt == 0 && stuck == 0) begin
        frame_len = $urandom_range(4, 64);
        if ($urandom_range(0, 19) == 0) stuck = $urandom_range(1, 80);
      end
      iRST = ($urandom_range(0, 999) == 0);
      tick();
    end
    iRST = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
